// File: rtl/s2p_pkg.sv
// Shared definitions for the round-robin serial-to-parallel scheduler.
// Holds the FSM state encoding, a constant clog2 helper and the default word width.
// Optional parity framing is selected by the S2P_PARITY_EN macro in the top level.
`timescale 1ns/1ps
package s2p_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEFAULT_WORD_W = 4;

  // Ceiling log2, usable in constant expressions; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/s2p_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Ports: req (requests), ptr (highest-priority index) -> pick_oh (one-hot),
//        pick_idx (binary index of the pick), any (at least one request set).
`timescale 1ns/1ps
module s2p_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [ID_W-1:0]    pick_idx,
  output logic               any
);

  int              idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr is always < NUM_REQ, so one subtraction suffices for the wrap.
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!any && req[sel]) begin
        any           = 1'b1;
        pick_idx      = sel;
        pick_oh[sel]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2p_rr_sched.sv
// Round-robin scheduler sharing one serial-to-parallel deserializer among NUM_REQ serial lanes.
// Ports: clk/rst (async active-high); req/sdata per lane in; gnt one-hot out; busy;
//        out_data/out_id/out_perr/out_valid with out_ready handshake; abort pulse on dropped frame.
// Macro S2P_PARITY_EN: frame carries a trailing even-parity bit and out_perr reports mismatches.
`timescale 1ns/1ps
module s2p_rr_sched
  import s2p_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = DEFAULT_WORD_W,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] sdata,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [WORD_W-1:0]  out_data,
  output logic [ID_W-1:0]    out_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_perr,
  output logic               abort
);

`ifdef S2P_PARITY_EN
  localparam int FL = WORD_W + 1;
`else
  localparam int FL = WORD_W;
`endif
  localparam int              CNT_W = clog2(FL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FL - 1);

  state_t             state_q,     state_d;
  logic [NUM_REQ-1:0] gnt_q,       gnt_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WORD_W-1:0]  shreg_q,     shreg_d;
  logic [ID_W-1:0]    ptr_q,       ptr_d;
  logic [ID_W-1:0]    cur_q,       cur_d;
  logic [WORD_W-1:0]  out_data_q,  out_data_d;
  logic [ID_W-1:0]    out_id_q,    out_id_d;
  logic               out_valid_q, out_valid_d;
  logic               out_perr_q,  out_perr_d;
  logic               abort_q,     abort_d;
  logic               busy_q,      busy_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               sbit;

  s2p_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Only the granted lane is ever sampled.
  assign sbit = sdata[cur_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    out_perr_d  = out_perr_q;
    abort_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_SHIFT;
          gnt_d   = pick_oh;
          cur_d   = pick_idx;
          cnt_d   = '0;
          // Pointer moves past the winner now, so an aborted frame still loses its turn.
          ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (!req[cur_q]) begin
          // Source withdrew mid-frame: drop the partial word.
          abort_d = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == LAST) begin
          gnt_d       = '0;
          cnt_d       = '0;
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          out_id_d    = cur_q;
`ifdef S2P_PARITY_EN
          // Last bit is the parity bit; data bits are already complete in shreg.
          out_data_d  = shreg_q;
          out_perr_d  = (^shreg_q) ^ sbit;
`else
          out_data_d  = {shreg_q[WORD_W-2:0], sbit};
          out_perr_d  = 1'b0;
`endif
        end else begin
          shreg_d = {shreg_q[WORD_W-2:0], sbit};
          cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      cur_q       <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_valid = out_valid_q;
  assign out_perr  = out_perr_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_s2p_rr_sched.sv
// Directed testbench for s2p_rr_sched: single frame, backpressure, RR order,
// abort, mid-frame reset and (under S2P_PARITY_EN) parity error reporting.
// Lanes act as serial sources: each drives bit j of its frame in its j-th granted cycle.
`timescale 1ns/1ps
module tb_s2p_rr_sched;

`ifdef S2P_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FLB = 5;
`else
  localparam bit PAR = 1'b0;
  localparam int FLB = 4;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] sdata;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] out_data;
  logic [1:0] out_id;
  logic       out_valid;
  logic       out_ready;
  logic       out_perr;
  logic       abort;

  s2p_rr_sched #(
    .NUM_REQ (4),
    .WORD_W  (4),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sdata     (sdata),
    .gnt       (gnt),
    .busy      (busy),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_perr  (out_perr),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] frame  [4];
  logic [3:0] exp_d  [4];
  logic       exp_pe [4];
  int         bitpos [4];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame for lane k carrying data d; pflip=1 corrupts the parity bit.
  task automatic load(input int k, input logic [3:0] d, input logic pflip);
    if (PAR) frame[k] = {d, (^d) ^ pflip};
    else     frame[k] = {1'b0, d};
    exp_d[k]  = d;
    exp_pe[k] = PAR ? pflip : 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    logic [4:0] f;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        f = frame[i];
        sdata[i] = (bitpos[i] < FLB) ? f[3'(FLB - 1 - bitpos[i])] : 1'b0;
        bitpos[i]++;
      end else begin
        sdata[i]  = 1'b0;
        bitpos[i] = 0;
      end
    end
  endtask

  // From IDLE with lane k winning: FLB grant cycles, then the word appears.
  task automatic expect_frame(input int k);
    for (int j = 0; j < FLB; j++) begin
      step();
      check("gnt", 32'(gnt), 32'(1) << k);
      check("abort_low", 32'(abort), 32'd0);
    end
    step();
    check("valid", 32'(out_valid), 32'd1);
    check("data", 32'(out_data), 32'(exp_d[k]));
    check("id", 32'(out_id), 32'(k));
    check("perr", 32'(out_perr), 32'(exp_pe[k]));
    check("gnt_hold", 32'(gnt), 32'd0);
  endtask

  // Accept cycle: word consumed, back in IDLE with no grant yet.
  task automatic idle_check();
    step();
    check("valid_clr", 32'(out_valid), 32'd0);
    check("gnt_bubble", 32'(gnt), 32'd0);
  endtask

  task automatic reset_outputs_check();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_perr", 32'(out_perr), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b0000;
    sdata     = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bitpos[i] = 0;
      load(i, 4'h0, 1'b0);
    end
    #1;
    reset_outputs_check();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source on lane 2, then backpressure while lane 0 waits.
    load(2, 4'hB, 1'b0);
    req = 4'b0100;
    expect_frame(2);
    check("busy_hold", 32'(busy), 32'd1);
    req = 4'b0001;
    load(0, 4'h6, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'hB);
      check("bp_id", 32'(out_id), 32'd2);
      check("bp_gnt", 32'(gnt), 32'd0);
    end
    out_ready = 1'b1;
    idle_check();
    expect_frame(0);
    req = 4'b0000;
    idle_check();

    // Abort: lane 1 withdraws after 2 bits; pointer is already past it, lane 3 is next.
    load(1, 4'h9, 1'b0);
    load(3, 4'h3, 1'b0);
    req = 4'b1010;
    step();
    check("ab_gnt0", 32'(gnt), 32'b0010);
    step();
    check("ab_gnt1", 32'(gnt), 32'b0010);
    req = 4'b1000;
    step();
    check("ab_pulse", 32'(abort), 32'd1);
    check("ab_gnt", 32'(gnt), 32'd0);
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    expect_frame(3);
    req = 4'b0000;
    idle_check();

    // Reset mid-frame, then first grant goes to the lowest request from 0.
    load(2, 4'hB, 1'b0);
    req = 4'b0100;
    step();
    check("mr_gnt", 32'(gnt), 32'b0100);
    step();
    rst = 1'b1;
    #1;
    reset_outputs_check();
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0110;
    load(1, 4'h9, 1'b0);
    expect_frame(1);
    req = 4'b0000;
    idle_check();

    // Round robin over all four lanes from a fresh pointer: 0,1,2,3,0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    load(0, 4'hB, 1'b0);
    load(1, 4'h6, 1'b0);
    load(2, 4'h9, 1'b0);
    load(3, 4'h3, 1'b0);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      expect_frame(r % 4);
      if (r == 4) req = 4'b0000;
      idle_check();
    end

    // Parity: good parity bit then corrupted parity bit, same data.
    load(2, 4'hB, 1'b0);
    req = 4'b0100;
    expect_frame(2);
    req = 4'b0000;
    idle_check();
    load(2, 4'hB, 1'b1);
    req = 4'b0100;
    expect_frame(2);
    req = 4'b0000;
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
